regfile_wb_arbiter: RTL and testbench
=====================================

Name: regfile_wb_arbiter

Overview:
- Shares the single register-file write port (we/addr_w/data_w) between N_REQ write-back requesters, e.g. ALU and load unit.
- Round-robin arbitration with valid/ready handshake; the winner is registered into one output stage that drives the register file.
- Keeps a pending-write scoreboard, one bit per architectural register, for issue-stage hazard detection.
- Sits between the execute/memory write-back sources and reg_file.

Parameters:
- ARCH, 32, data width in bits.
- REGFILE_DEPTH, 32, number of registers; AW = $clog2(REGFILE_DEPTH).
- N_REQ, 2, number of write-back requesters (>=2); index 0 is the lowest index.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  N_REQ  requester i has a write-back.
- req_addr  in  N_REQ*AW  destination register; slice i = [i*AW +: AW].
- req_data  in  N_REQ*ARCH  write data; slice i = [i*ARCH +: ARCH].
- req_ready  out  N_REQ  one-hot grant; transfer happens when req_valid[i] & req_ready[i].
- issue_valid  in  1  an instruction with a destination register is issued.
- issue_addr  in  AW  destination register of the issued instruction.
- we  out  1  register-file write enable.
- addr_w  out  AW  register-file write address.
- data_w  out  ARCH  register-file write data.
- pending  out  REGFILE_DEPTH  scoreboard; bit r=1 means a write to xr is outstanding.

Behaviour:
- Reset (async, rst=1): we=0, addr_w=0, data_w=0, pending=0, rr_ptr=0. req_ready then depends only on req_valid and rr_ptr=0.
- Arbitration (combinational):
  - Scan requesters starting at rr_ptr, ascending, with wrap-around.
  - The first i with req_valid[i]=1 gets req_ready[i]=1. All other ready bits are 0.
  - If no valid request, req_ready=0.
  - req_ready never depends on any requester's data or address.
  - At most one transfer per cycle.
- Pointer update: on a transfer from requester i, rr_ptr <= (i+1) mod N_REQ. With no transfer, rr_ptr holds.
- Output stage (1-cycle latency, never stalls):
  - Transfer with addr!=0: next cycle we=1, addr_w=addr, data_w=data.
  - Transfer with addr==0 (write to x0): accepted, ready=1, but we=0 next cycle, addr_w/data_w hold, no scoreboard effect.
  - No transfer: we=0, addr_w/data_w hold their previous values.
- Scoreboard:
  - Set: issue_valid=1 and issue_addr!=0 sets pending[issue_addr] at the clock edge.
  - Clear: on the clock edge that ends a cycle with we=1, pending[addr_w] is cleared. The data is readable from reg_file the cycle after we.
  - Simultaneous set and clear of the same address: set wins, so the bit stays 1 (a newer writer is in flight).
  - Set and clear of different addresses both take effect.
  - pending[0] is always 0.
  - No counting: a second issue to an already-pending register keeps the bit at 1. The first write-back to that register clears it. Issue logic must not issue a second writer to a pending register.
- Reset mid-operation: the in-flight output-stage write is dropped (we=0 immediately, asynchronously); all pending bits are cleared.
- Requesters must hold valid/addr/data stable until ready. The arbiter does not check this.

Optional Feature:
- Macro: REGFILE_WB_BYPASS_EN.
- With the macro defined, these ports are added:
  - rf_addr_r1 in AW, rf_addr_r2 in AW.
  - rf_data_r1 in ARCH, rf_data_r2 in ARCH (register-file read outputs).
  - fwd_data_r1 out ARCH, fwd_data_r2 out ARCH.
- Forwarding rule (combinational): fwd_data_rk = (we && addr_w==rf_addr_rk && rf_addr_rk!=0) ? data_w : rf_data_rk.
- Effect: a value is usable in the same cycle it is written, and pending[r] may be treated as already satisfied during that we cycle.
- Without the macro: the ports are absent, there is no forwarding logic, and consumers wait for pending[r]=0.

Test Plan:
- Reset release, no requests -> req_ready=0, we=0, pending=0. Assert rst mid-write (we=1) -> we drops to 0 immediately and pending=0.
- Single request: req0 valid, addr=5, data=0xDEADBEEF -> ready[0]=1 that cycle; next cycle we=1, addr_w=5, data_w=0xDEADBEEF; the cycle after, we=0.
- Both requesters valid for 4 cycles (N_REQ=2, rr_ptr=0) -> grants 0,1,0,1. we=1 on the 4 following cycles with the matching addr/data.
- Write to x0: req1 addr=0, data=0x1234 -> ready[1]=1, we stays 0, pending unchanged, rr_ptr advances to 0.
- Scoreboard: issue x7 -> pending[7]=1. Write-back x7 with issue x7 in the cycle we=1 -> pending[7] stays 1. Next write-back x7 with no new issue -> pending[7]=0. issue x0 -> pending stays 0.
- REGFILE_WB_BYPASS_EN: during we=1 addr_w=9 data_w=0xA5A5A5A5 with rf_addr_r1=9 and rf_data_r1=0 -> fwd_data_r1=0xA5A5A5A5. rf_addr_r2=0 -> fwd_data_r2=rf_data_r2.

Source files
------------

// File: rtl/regfile_wb_arbiter.sv
// Round-robin write-back arbiter for the single register-file write port, with a pending-write scoreboard.
// Optional same-cycle read forwarding is enabled by defining REGFILE_WB_BYPASS_EN.
module regfile_wb_arbiter #(
    parameter int ARCH          = 32,
    parameter int REGFILE_DEPTH = 32,
    parameter int N_REQ         = 2,
    localparam int AW           = $clog2(REGFILE_DEPTH)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_REQ-1:0]         req_valid,
    input  logic [N_REQ*AW-1:0]      req_addr,
    input  logic [N_REQ*ARCH-1:0]    req_data,
    output logic [N_REQ-1:0]         req_ready,
    input  logic                     issue_valid,
    input  logic [AW-1:0]            issue_addr,
    output logic                     we,
    output logic [AW-1:0]            addr_w,
    output logic [ARCH-1:0]          data_w,
    output logic [REGFILE_DEPTH-1:0] pending
`ifdef REGFILE_WB_BYPASS_EN
    ,
    input  logic [AW-1:0]            rf_addr_r1,
    input  logic [AW-1:0]            rf_addr_r2,
    input  logic [ARCH-1:0]          rf_data_r1,
    input  logic [ARCH-1:0]          rf_data_r2,
    output logic [ARCH-1:0]          fwd_data_r1,
    output logic [ARCH-1:0]          fwd_data_r2
`endif
);

    localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    typedef struct packed {
        logic            we;
        logic [AW-1:0]   addr;
        logic [ARCH-1:0] data;
    } wb_t;

    logic [PW-1:0]            rr_ptr;
    logic [N_REQ-1:0]         grant;
    logic                     xfer;
    int                       gsel;
    logic [AW-1:0]            sel_addr;
    logic [ARCH-1:0]          sel_data;
    logic [REGFILE_DEPTH-1:0] pend_nxt;
    wb_t                      wb_q;

    // Grant depends only on valid bits and the pointer, never on payload.
    always_comb begin
        grant = '0;
        xfer  = 1'b0;
        gsel  = 0;
        for (int k = 0; k < N_REQ; k++) begin
            if (!xfer && req_valid[(int'(rr_ptr) + k) % N_REQ]) begin
                xfer  = 1'b1;
                gsel  = (int'(rr_ptr) + k) % N_REQ;
                grant[(int'(rr_ptr) + k) % N_REQ] = 1'b1;
            end
        end
    end

    assign req_ready = grant;
    assign sel_addr  = req_addr[gsel*AW +: AW];
    assign sel_data  = req_data[gsel*ARCH +: ARCH];

    // Issue is applied after the write-back clear so a same-register reissue keeps the bit set.
    always_comb begin
        pend_nxt = pending;
        if (wb_q.we)
            pend_nxt[wb_q.addr] = 1'b0;
        if (issue_valid && issue_addr != '0)
            pend_nxt[issue_addr] = 1'b1;
        pend_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr  <= '0;
            wb_q    <= '0;
            pending <= '0;
        end else begin
            pending <= pend_nxt;
            wb_q.we <= xfer && (sel_addr != '0);
            if (xfer) begin
                rr_ptr <= PW'((gsel + 1) % N_REQ);
                // x0 writes are swallowed: the port keeps its last address/data.
                if (sel_addr != '0) begin
                    wb_q.addr <= sel_addr;
                    wb_q.data <= sel_data;
                end
            end
        end
    end

    assign we     = wb_q.we;
    assign addr_w = wb_q.addr;
    assign data_w = wb_q.data;

`ifdef REGFILE_WB_BYPASS_EN
    assign fwd_data_r1 = (wb_q.we && wb_q.addr == rf_addr_r1 && rf_addr_r1 != '0) ? wb_q.data : rf_data_r1;
    assign fwd_data_r2 = (wb_q.we && wb_q.addr == rf_addr_r2 && rf_addr_r2 != '0) ? wb_q.data : rf_data_r2;
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter: directed scenarios plus a randomized run against a behavioural model.
module tb_regfile_wb_arbiter;

    localparam int ARCH  = 32;
    localparam int DEPTH = 32;
    localparam int N     = 2;
    localparam int AW    = 5;

    logic               clk;
    logic               rst;
    logic [N-1:0]       req_valid;
    logic [N*AW-1:0]    req_addr;
    logic [N*ARCH-1:0]  req_data;
    logic [N-1:0]       req_ready;
    logic               issue_valid;
    logic [AW-1:0]      issue_addr;
    logic               we;
    logic [AW-1:0]      addr_w;
    logic [ARCH-1:0]    data_w;
    logic [DEPTH-1:0]   pending;
`ifdef REGFILE_WB_BYPASS_EN
    logic [AW-1:0]      rf_addr_r1, rf_addr_r2;
    logic [ARCH-1:0]    rf_data_r1, rf_data_r2;
    logic [ARCH-1:0]    fwd_data_r1, fwd_data_r2;
`endif

    int checks = 0;
    int failures = 0;

    regfile_wb_arbiter #(.ARCH(ARCH), .REGFILE_DEPTH(DEPTH), .N_REQ(N)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_addr(req_addr), .req_data(req_data), .req_ready(req_ready),
        .issue_valid(issue_valid), .issue_addr(issue_addr),
        .we(we), .addr_w(addr_w), .data_w(data_w), .pending(pending)
`ifdef REGFILE_WB_BYPASS_EN
        ,
        .rf_addr_r1(rf_addr_r1), .rf_addr_r2(rf_addr_r2),
        .rf_data_r1(rf_data_r1), .rf_data_r2(rf_data_r2),
        .fwd_data_r1(fwd_data_r1), .fwd_data_r2(fwd_data_r2)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic set_req(input int i, input logic v, input logic [AW-1:0] a, input logic [ARCH-1:0] d);
        req_valid[i] = v;
        req_addr[i*AW +: AW] = a;
        req_data[i*ARCH +: ARCH] = d;
    endtask

    task automatic idle_inputs();
        req_valid = '0;
        req_addr = '0;
        req_data = '0;
        issue_valid = 1'b0;
        issue_addr = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b1;
        set_req(1, 1'b1, 5'd3, 32'h1);
        tick();
        tick();
        checks++;
        if (req_ready !== 2'b10) begin
            failures++;
            $display("FAIL reset_ready_ptr0 got=%b want=10", req_ready);
        end
        idle_inputs();
        rst = 1'b0;
        #1;
        checks++;
        if (req_ready !== 2'b00 || we !== 1'b0 || pending !== '0 || addr_w !== '0 || data_w !== '0) begin
            failures++;
            $display("FAIL reset_state ready=%b we=%b pend=%h addr=%0d data=%h want 00/0/0/0/0",
                     req_ready, we, pending, addr_w, data_w);
        end
    endtask

    task automatic test_single();
        set_req(0, 1'b1, 5'd5, 32'hDEADBEEF);
        #1;
        checks++;
        if (req_ready !== 2'b01) begin
            failures++;
            $display("FAIL single_ready got=%b want=01", req_ready);
        end
        tick();
        idle_inputs();
        checks++;
        if (we !== 1'b1 || addr_w !== 5'd5 || data_w !== 32'hDEADBEEF) begin
            failures++;
            $display("FAIL single_write we=%b addr=%0d data=%h want 1/5/deadbeef", we, addr_w, data_w);
        end
        tick();
        checks++;
        if (we !== 1'b0 || addr_w !== 5'd5 || data_w !== 32'hDEADBEEF) begin
            failures++;
            $display("FAIL single_after we=%b addr=%0d data=%h want 0/5/deadbeef", we, addr_w, data_w);
        end
    endtask

    task automatic test_back_to_back();
        logic [AW-1:0]   exp_a;
        logic [ARCH-1:0] exp_d;
        do_reset();
        for (int c = 0; c <= 4; c++) begin
            if (c > 0) begin
                exp_a = ((c - 1) % 2 == 0) ? AW'(10 + c - 1) : AW'(20 + c - 1);
                exp_d = 32'hB000_0000 + ARCH'(exp_a);
                checks++;
                if (we !== 1'b1 || addr_w !== exp_a || data_w !== exp_d) begin
                    failures++;
                    $display("FAIL b2b_write[%0d] we=%b addr=%0d data=%h want 1/%0d/%h",
                             c - 1, we, addr_w, data_w, exp_a, exp_d);
                end
            end
            if (c < 4) begin
                set_req(0, 1'b1, AW'(10 + c), 32'hB000_0000 + 32'(10 + c));
                set_req(1, 1'b1, AW'(20 + c), 32'hB000_0000 + 32'(20 + c));
                #1;
                checks++;
                if (req_ready !== ((c % 2 == 0) ? 2'b01 : 2'b10)) begin
                    failures++;
                    $display("FAIL b2b_grant[%0d] got=%b want=%b", c, req_ready, (c % 2 == 0) ? 2'b01 : 2'b10);
                end
                tick();
            end else begin
                idle_inputs();
            end
        end
    endtask

    task automatic test_x0();
        logic [AW-1:0]   old_a;
        logic [ARCH-1:0] old_d;
        logic [DEPTH-1:0] old_p;
        old_a = addr_w;
        old_d = data_w;
        old_p = pending;
        set_req(1, 1'b1, 5'd0, 32'h1234);
        #1;
        checks++;
        if (req_ready !== 2'b10) begin
            failures++;
            $display("FAIL x0_ready got=%b want=10", req_ready);
        end
        tick();
        idle_inputs();
        checks++;
        if (we !== 1'b0 || addr_w !== old_a || data_w !== old_d || pending !== old_p) begin
            failures++;
            $display("FAIL x0_nowrite we=%b addr=%0d data=%h pend=%h want 0/%0d/%h/%h",
                     we, addr_w, data_w, pending, old_a, old_d, old_p);
        end
        req_valid = 2'b11;
        #1;
        checks++;
        if (req_ready !== 2'b01) begin
            failures++;
            $display("FAIL x0_ptr_wrap got=%b want=01", req_ready);
        end
        idle_inputs();
        #1;
    endtask

    task automatic test_scoreboard();
        do_reset();
        issue_valid = 1'b1;
        issue_addr = 5'd7;
        tick();
        idle_inputs();
        checks++;
        if (pending !== 32'h0000_0080) begin
            failures++;
            $display("FAIL sb_set got=%h want=00000080", pending);
        end
        set_req(0, 1'b1, 5'd7, 32'h7777);
        tick();
        idle_inputs();
        issue_valid = 1'b1;
        issue_addr = 5'd7;
        tick();
        idle_inputs();
        checks++;
        if (pending !== 32'h0000_0080) begin
            failures++;
            $display("FAIL sb_set_wins got=%h want=00000080", pending);
        end
        set_req(0, 1'b1, 5'd7, 32'h7778);
        tick();
        idle_inputs();
        issue_valid = 1'b1;
        issue_addr = 5'd12;
        tick();
        idle_inputs();
        checks++;
        if (pending !== 32'h0000_1000) begin
            failures++;
            $display("FAIL sb_clear_and_set got=%h want=00001000", pending);
        end
        issue_valid = 1'b1;
        issue_addr = 5'd0;
        tick();
        idle_inputs();
        checks++;
        if (pending !== 32'h0000_1000) begin
            failures++;
            $display("FAIL sb_issue_x0 got=%h want=00001000", pending);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        set_req(0, 1'b1, 5'd4, 32'hCAFE_0004);
        issue_valid = 1'b1;
        issue_addr = 5'd4;
        tick();
        idle_inputs();
        checks++;
        if (we !== 1'b1 || pending !== 32'h0000_0010) begin
            failures++;
            $display("FAIL rmid_pre we=%b pend=%h want 1/00000010", we, pending);
        end
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (we !== 1'b0 || pending !== '0 || addr_w !== '0) begin
            failures++;
            $display("FAIL rmid_async we=%b pend=%h addr=%0d want 0/0/0", we, pending, addr_w);
        end
        tick();
        rst = 1'b0;
        #1;
    endtask

    // Reference: a pointer, one-deep write slot and a bit per register, updated from the written rules.
    task automatic test_random();
        int              m_ptr;
        bit              m_we;
        logic [AW-1:0]   m_addr;
        logic [ARCH-1:0] m_data;
        bit              m_pend[DEPTH];
        int              g;
        logic [N-1:0]    exp_rdy;
        logic [DEPTH-1:0] exp_p;
        logic [AW-1:0]   ga;
        do_reset();
        m_ptr = 0; m_we = 0; m_addr = '0; m_data = '0;
        for (int r = 0; r < DEPTH; r++) m_pend[r] = 0;
        for (int cyc = 0; cyc < 300; cyc++) begin
            for (int i = 0; i < N; i++)
                set_req(i, 1'($urandom_range(0, 1)), AW'($urandom_range(0, DEPTH - 1)), $urandom);
            issue_valid = 1'($urandom_range(0, 1));
            issue_addr = AW'($urandom_range(0, DEPTH - 1));
            #1;
            g = -1;
            for (int k = 0; k < N; k++)
                if (g < 0 && req_valid[(m_ptr + k) % N]) g = (m_ptr + k) % N;
            exp_rdy = '0;
            if (g >= 0) exp_rdy[g] = 1'b1;
            checks++;
            if (req_ready !== exp_rdy) begin
                failures++;
                $display("FAIL rand_ready[%0d] got=%b want=%b", cyc, req_ready, exp_rdy);
            end
            if (m_we) m_pend[m_addr] = 0;
            if (issue_valid && issue_addr != 0) m_pend[issue_addr] = 1;
            m_we = 0;
            if (g >= 0) begin
                m_ptr = (g + 1) % N;
                ga = req_addr[g*AW +: AW];
                if (ga != 0) begin
                    m_we = 1;
                    m_addr = ga;
                    m_data = req_data[g*ARCH +: ARCH];
                end
            end
            tick();
            for (int r = 0; r < DEPTH; r++) exp_p[r] = m_pend[r];
            checks++;
            if (we !== m_we || addr_w !== m_addr || data_w !== m_data || pending !== exp_p) begin
                failures++;
                $display("FAIL rand_out[%0d] we=%b addr=%0d data=%h pend=%h want %b/%0d/%h/%h",
                         cyc, we, addr_w, data_w, pending, m_we, m_addr, m_data, exp_p);
            end
        end
        idle_inputs();
    endtask

`ifdef REGFILE_WB_BYPASS_EN
    task automatic test_bypass();
        logic [ARCH-1:0] r2;
        r2 = $urandom;
        do_reset();
        set_req(0, 1'b1, 5'd9, 32'hA5A5A5A5);
        tick();
        idle_inputs();
        rf_addr_r1 = 5'd9; rf_data_r1 = '0;
        rf_addr_r2 = 5'd0; rf_data_r2 = r2;
        #1;
        checks++;
        if (fwd_data_r1 !== 32'hA5A5A5A5 || fwd_data_r2 !== r2) begin
            failures++;
            $display("FAIL bypass_fwd r1=%h r2=%h want a5a5a5a5/%h", fwd_data_r1, fwd_data_r2, r2);
        end
        tick();
        checks++;
        if (fwd_data_r1 !== 32'h0) begin
            failures++;
            $display("FAIL bypass_idle r1=%h want 0", fwd_data_r1);
        end
    endtask
`endif

    initial begin
        rst = 1'b0;
        idle_inputs();
`ifdef REGFILE_WB_BYPASS_EN
        rf_addr_r1 = '0; rf_addr_r2 = '0; rf_data_r1 = '0; rf_data_r2 = '0;
`endif
        test_reset();
        test_single();
        test_back_to_back();
        test_x0();
        test_scoreboard();
        test_reset_mid();
        test_random();
`ifdef REGFILE_WB_BYPASS_EN
        test_bypass();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
